// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_ctrl
// Brief    : Handshaked, latched multi-digit seven-segment controller with
//            leading-zero blanking; per-digit blinking when HEX_DISPLAY_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_ctrl #(
  parameter int DIGITS         = 8,
  parameter int BLINK_DIV_LOG2 = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] value_i,
  input  logic                blank_lz_i,
  input  logic [DIGITS-1:0]   blink_mask_i,
  output logic                ready_o,
  output logic                updated_o,
  output logic [7*DIGITS-1:0] hex_out_o
);

  localparam int               IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [1:0]       S_IDLE    = 2'd0;
  localparam logic [1:0]       S_SCAN    = 2'd1;
  localparam logic [1:0]       S_COMMIT  = 2'd2;
  localparam logic [6:0]       SEG_BLANK = 7'h7F;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   lz_run_q, lz_run_d;
  logic [4*DIGITS-1:0]    value_q, value_d;
  logic [DIGITS-1:0][6:0] shadow_q, shadow_d;
  logic [DIGITS-1:0][6:0] disp_q, disp_d;
  logic [DIGITS-1:0][6:0] hex_q, hex_d;
  logic                   updated_q, updated_d;
  logic [3:0]             w_nibble;

  function automatic logic [6:0] f_encode(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_nibble = value_q[{idx_q, 2'b00} +: 4];

  // Scan runs MSB first so the leading-zero run can be tracked in one flag.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lz_run_d  = lz_run_q;
    value_d   = value_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    updated_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          value_d  = value_i;
          lz_run_d = blank_lz_i;
          idx_d    = IDX_LAST;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (lz_run_q && (w_nibble == 4'h0) && (idx_q != '0)) begin
          shadow_d[idx_q] = SEG_BLANK;
        end else begin
          lz_run_d        = 1'b0;
          shadow_d[idx_q] = f_encode(w_nibble);
        end
        if (idx_q == '0) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_COMMIT: begin
        disp_d    = shadow_q;
        updated_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef HEX_DISPLAY_BLINK_EN
  logic [BLINK_DIV_LOG2-1:0] presc_q;
  logic                      w_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign w_phase = presc_q[BLINK_DIV_LOG2-1];

  always_comb begin
    hex_d = disp_q;
    for (int i = 0; i < DIGITS; i++) begin
      hex_d[i] = disp_q[i] | {7{w_phase & blink_mask_i[i]}};
    end
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_mask_i;
  assign hex_d          = disp_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      lz_run_q  <= 1'b0;
      value_q   <= '0;
      shadow_q  <= {DIGITS{SEG_BLANK}};
      disp_q    <= {DIGITS{SEG_BLANK}};
      hex_q     <= {DIGITS{SEG_BLANK}};
      updated_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lz_run_q  <= lz_run_d;
      value_q   <= value_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      hex_q     <= hex_d;
      updated_q <= updated_d;
    end
  end

  assign ready_o   = (state_q == S_IDLE);
  assign updated_o = updated_q;
  assign hex_out_o = hex_q;

endmodule
`default_nettype wire
